// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-bank constants and types for the write scheduler
package regfile_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_COUNT      = 32;
    localparam int ZERO_REG       = 0;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]           reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over req_valid with a rotating priority pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] onehot;

    // Prefer requests at or above ptr; fall back to the lowest valid request to wrap around
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++)
            masked[i] = req_valid[i] && (PW'(i) >= ptr);
        pick   = (|masked) ? masked : req_valid;
        onehot = '0;
        gidx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pick[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                gidx      = PW'(i);
            end
        grant = reset ? onehot : '0;
    end

    // Pointer moves just past the winner after each transfer
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            ptr <= '0;
        else if (|grant)
            ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);

endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: round-robin sharing of the register bank write port; optional busy scoreboard under REGFILE_SCOREBOARD_EN
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_sel,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_sel_in,
    output logic [DATA_WIDTH-1:0]         rf_data_in,
    input  logic                          rsv_valid,
    input  logic [ADDR_WIDTH-1:0]         rsv_sel,
    input  logic                          flush,
    output logic [2**ADDR_WIDTH-1:0]      busy
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic [NUM_REQ-1:0]    grant;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = grant;

    // Grant is one-hot, so OR-ing the gated slices selects the winner
    always_comb begin
        fire = |grant;
        sel  = '0;
        data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel  = sel  | (grant[i] ? req_sel[i*ADDR_WIDTH +: ADDR_WIDTH]  : '0);
            data = data | (grant[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
        end
    end

    // Single write stage; x0 transfers are accepted but never enable the bank
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rf_we      <= 1'b0;
            rf_sel_in  <= '0;
            rf_data_in <= '0;
        end else begin
            rf_we <= fire && (sel != ADDR_WIDTH'(ZERO_REG));
            if (fire) begin
                rf_sel_in  <= sel;
                rf_data_in <= data;
            end
        end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0] busy_q;

    // Release on the write cycle, reserve wins a same-edge collision, flush beats both
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            busy_q <= '0;
        else if (flush)
            busy_q <= '0;
        else
            busy_q <= (busy_q & ~(rf_we ? NREG'(1) << rf_sel_in : '0))
                    | ((rsv_valid && rsv_sel != ADDR_WIDTH'(ZERO_REG)) ? NREG'(1) << rsv_sel : '0);

    assign busy = busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_sel, flush};
    assign busy       = '0;
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: randomized and directed checks against a behavioural model; honours REGFILE_SCOREBOARD_EN
module tb_regfile_write_scheduler;

    localparam int N = 2;
`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*5-1:0]    req_sel;
    logic [N*32-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rf_we;
    logic [4:0]        rf_sel_in;
    logic [31:0]       rf_data_in;
    logic              rsv_valid = 1'b0;
    logic [4:0]        rsv_sel = '0;
    logic              flush = 1'b0;
    logic [31:0]       busy;

    logic [4:0]  sel  [N];
    logic [31:0] data [N];

    always_comb
        for (int i = 0; i < N; i++) begin
            req_sel[i*5 +: 5]   = sel[i];
            req_data[i*32 +: 32] = data[i];
        end

    always #5 clock = ~clock;

    regfile_write_scheduler #(.NUM_REQ(N), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_we      (rf_we),
        .rf_sel_in  (rf_sel_in),
        .rf_data_in (rf_data_in),
        .rsv_valid  (rsv_valid),
        .rsv_sel    (rsv_sel),
        .flush      (flush),
        .busy       (busy)
    );

    logic [31:0] dut_bank [32] = '{default: 32'd0};
    always @(posedge clock)
        if (rf_we) dut_bank[rf_sel_in] <= rf_data_in;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_ptr    = 0;
    bit          m_we     = 1'b0;
    logic [4:0]  m_sel    = '0;
    logic [31:0] m_data   = '0;
    logic [31:0] m_busy   = '0;
    logic [31:0] m_bank [32] = '{default: 32'd0};
    int          last_g   = -1;
    logic [N-1:0] obs_ready;
    logic         obs_we;
    logic [31:0]  obs_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_we = 1'b0; m_sel = '0; m_data = '0; m_busy = '0;
    endtask

    function automatic int model_grant();
        if (!reset) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_update(input int g);
        last_g = g;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_we) m_bank[m_sel] = m_data;
        if (SB) begin
            if (flush) m_busy = '0;
            else begin
                if (m_we) m_busy[m_sel] = 1'b0;
                if (rsv_valid && rsv_sel != 0) m_busy[rsv_sel] = 1'b1;
            end
        end
        if (g >= 0) begin
            m_we   = sel[g] != 0;
            m_sel  = sel[g];
            m_data = data[g];
            m_ptr  = (g + 1) % N;
        end else
            m_we = 1'b0;
    endtask

    task automatic observe(output int g);
        if (!reset) model_reset();
        g = model_grant();
        obs_ready = req_ready;
        obs_we    = rf_we;
        obs_busy  = busy;
        check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : 64'd1 << g);
        check("rf_we", 64'(rf_we), 64'(m_we));
        check("rf_sel_in", 64'(rf_sel_in), 64'(m_sel));
        check("rf_data_in", 64'(rf_data_in), 64'(m_data));
        check("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic step();
        int g;
        @(negedge clock);
        observe(g);
        @(posedge clock);
        model_update(g);
        #1;
    endtask

    initial begin
        int g;
        for (int i = 0; i < N; i++) begin sel[i] = '0; data[i] = '0; end
        #1 reset = 1'b0;
        req_valid = 2'b11;
        step();
        step();
        check("rst_ready", 64'(obs_ready), 64'd0);
        reset = 1'b1;
        step();
        check("first_grant", 64'(obs_ready), 64'd1);

        req_valid = 2'b10; sel[1] = 5'd5; data[1] = 32'h0000_00AB;
        step();
        req_valid = 2'b00;
        step();
        check("single_we", 64'(obs_we), 64'd1);
        step();
        check("bank_x5", 64'(dut_bank[5]), 64'h0000_00AB);

        req_valid = 2'b11; sel[0] = 5'd1; data[0] = 32'h11; sel[1] = 5'd2; data[1] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fair_grant", 64'(obs_ready), (i % 2) ? 64'd2 : 64'd1);
        end

        req_valid = 2'b01; sel[0] = 5'd0; data[0] = 32'hFFFF_FFFF;
        step();
        check("x0_ready", 64'(obs_ready), 64'd1);
        req_valid = 2'b11;
        step();
        check("x0_we", 64'(obs_we), 64'd0);
        check("x0_ptr", 64'(obs_ready), 64'd2);
        req_valid = 2'b00;
        step();
        step();
        check("bank_x0", 64'(dut_bank[0]), 64'd0);

        rsv_valid = 1'b1; rsv_sel = 5'd7;
        step();
        rsv_valid = 1'b0;
        req_valid = 2'b01; sel[0] = 5'd7; data[0] = 32'h77;
        step();
        check("sb_set", 64'(obs_busy[7]), 64'(SB));
        req_valid = 2'b00; rsv_valid = 1'b1;
        step();
        rsv_valid = 1'b0; req_valid = 2'b01; data[0] = 32'h777;
        step();
        check("sb_keep", 64'(obs_busy[7]), 64'(SB));
        req_valid = 2'b00;
        step();
        step();
        check("sb_clear", 64'(obs_busy[7]), 64'd0);
        rsv_valid = 1'b1; rsv_sel = 5'd0;
        step();
        rsv_valid = 1'b0;
        step();
        check("sb_x0", 64'(obs_busy[0]), 64'd0);

        rsv_valid = 1'b1; rsv_sel = 5'd7;
        step();
        rsv_sel = 5'd8;
        step();
        rsv_valid = 1'b0;
        step();
        check("sb_pre_flush", 64'(obs_busy), SB ? 64'h180 : 64'd0);
        flush = 1'b1; rsv_valid = 1'b1; rsv_sel = 5'd3;
        step();
        flush = 1'b0; rsv_valid = 1'b0;
        step();
        check("sb_flush", 64'(obs_busy), 64'd0);

        req_valid = 2'b01; sel[0] = 5'd9; data[0] = 32'h99;
        @(negedge clock);
        observe(g);
        check("mid_ready", 64'(obs_ready), 64'd1);
        #1 reset = 1'b0;
        @(posedge clock);
        model_update(g);
        #1 req_valid = 2'b00;
        step();
        check("mid_we", 64'(obs_we), 64'd0);
        reset = 1'b1;
        step();
        check("mid_we2", 64'(obs_we), 64'd0);
        check("bank_x9", 64'(dut_bank[9]), 64'd0);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!(req_valid[i] && last_g != i)) begin
                    req_valid[i] = ($urandom % 4) != 0;
                    sel[i]       = 5'($urandom);
                    data[i]      = $urandom;
                end
            rsv_valid = $urandom % 2;
            rsv_sel   = 5'($urandom);
            flush     = ($urandom % 20) == 0;
            reset     = ($urandom % 64) != 0;
            step();
        end
        reset = 1'b1; req_valid = '0; rsv_valid = 1'b0; flush = 1'b0;
        step();
        step();
        for (int r = 0; r < 32; r++)
            check("bank", 64'(dut_bank[r]), 64'(m_bank[r]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
